// File: rtl/de2_70_sysid_pkg.sv
// de2_70_sysid_pkg: shared FSM states and sysid word constants
package de2_70_sysid_pkg;
  typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE} state_t;
  localparam int SYSID_WORD_ID = 0;
  localparam int SYSID_WORD_TS = 1;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1547560866;
  localparam logic [1:0] MAX_RETRIES = 2'd3;
endpackage

// File: rtl/de2_70_avm_read_xact.sv
// de2_70_avm_read_xact: single Avalon-MM read handshake with per-transaction timeout
module de2_70_avm_read_xact #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_wait,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        o_accept,
  output logic        o_valid,
  output logic        o_err,
  output logic [31:0] o_data
);
  logic [15:0] r_cnt;
  logic        w_active;
  always_comb begin
    w_active = i_req | i_wait;
    o_accept = i_req & ~avm_waitrequest;
    // data is only taken for our own pending read (or a zero-latency accept)
    o_valid  = avm_readdatavalid & (i_wait | o_accept);
    o_err    = w_active & ~o_valid & (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    o_data   = avm_readdata;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) r_cnt <= '0;
    else r_cnt <= (!w_active || o_valid || o_err) ? '0 : r_cnt + 16'd1;
endmodule

// File: rtl/de2_70_sysid_checker.sv
// de2_70_sysid_checker: reads sysid words 0/1 and compares them to build constants.
// Optional SYSID_CHECKER_RETRY_EN retries a failed check up to MAX_RETRIES times.
module de2_70_sysid_checker
  import de2_70_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          ADDR_W         = 1,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              boot_ok,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout_err,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
`ifdef SYSID_CHECKER_RETRY_EN
  , output logic [1:0]      retry_count
`endif
);
  state_t      r_state, w_next;
  logic        r_auto, r_id_ok, r_ts_ok, r_to;
  logic [31:0] r_id, r_ts, w_data;
  logic [1:0]  r_retry;
  logic        w_req, w_wait, w_ts, w_accept, w_valid, w_err, w_retry, w_launch;

  assign w_req  = (r_state == ID_REQ) || (r_state == TS_REQ);
  assign w_wait = (r_state == ID_WAIT) || (r_state == TS_WAIT);
  assign w_ts   = (r_state == TS_REQ) || (r_state == TS_WAIT);

  de2_70_avm_read_xact #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_xact (
    .clock(clock), .reset(reset), .i_req(w_req), .i_wait(w_wait),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata), .o_accept(w_accept), .o_valid(w_valid),
    .o_err(w_err), .o_data(w_data)
  );

`ifdef SYSID_CHECKER_RETRY_EN
  // an id mismatch still reads the timestamp; the verdict is taken at the end
  assign w_retry = (w_err || (w_ts && w_valid && !(r_id_ok && w_data == EXPECTED_TS)))
                   && r_retry != MAX_RETRIES;
  assign retry_count = r_retry;
`else
  assign w_retry = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = (start || r_auto) ? ID_REQ : IDLE;
      DONE: w_next = start ? ID_REQ : DONE;
      ID_REQ, ID_WAIT, TS_REQ, TS_WAIT:
        w_next = w_retry ? ID_REQ : w_err ? DONE :
                 w_valid ? (w_ts ? DONE : TS_REQ) :
                 w_accept ? (w_ts ? TS_WAIT : ID_WAIT) : r_state;
      default: w_next = IDLE;
    endcase
  end

  assign w_launch = (r_state == IDLE || r_state == DONE) && w_next == ID_REQ;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_auto  <= AUTO_START != 0;
      r_id_ok <= 1'b0;
      r_ts_ok <= 1'b0;
      r_to    <= 1'b0;
      r_id    <= '0;
      r_ts    <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_next;
      r_auto  <= 1'b0;
      if (w_valid && !w_ts) begin
        r_id    <= w_data;
        r_id_ok <= w_data == EXPECTED_ID;
      end
      if (w_valid && w_ts) begin
        r_ts    <= w_data;
        r_ts_ok <= w_data == EXPECTED_TS;
      end
      if (w_err) r_to <= 1'b1;
      if (w_launch || w_retry) begin
        r_id_ok <= 1'b0;
        r_ts_ok <= 1'b0;
        r_to    <= 1'b0;
        r_retry <= w_launch ? 2'd0 : r_retry + 2'd1;
      end
    end

  assign avm_read    = w_req;
  assign avm_address = ADDR_W'(w_ts ? SYSID_WORD_TS : SYSID_WORD_ID);
  assign busy        = w_req || w_wait;
  assign done        = r_state == DONE;
  assign boot_ok     = done && r_id_ok && r_ts_ok && !r_to;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout_err = r_to;
  assign id_value    = r_id;
  assign ts_value    = r_ts;
endmodule

// File: tb/tb_de2_70_sysid_checker.sv
// tb_de2_70_sysid_checker: directed checks of the sysid checker against a small slave model
module tb_de2_70_sysid_checker;
  localparam logic [31:0] TS_GOOD = 32'd1547560866;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [0:0] avm_address;
  logic avm_read, wr, rdv, busy, done, boot_ok, id_ok, ts_ok, timeout_err;
  logic [31:0] rd, id_value, ts_value;
`ifdef SYSID_CHECKER_RETRY_EN
  logic [1:0] retry_count;
`endif

  always #5 clk = ~clk;

  de2_70_sysid_checker #(.TIMEOUT_CYCLES(10)) dut (
    .clock(clk), .reset(rst), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(wr),
    .avm_readdata(rd), .avm_readdatavalid(rdv),
    .busy(busy), .done(done), .boot_ok(boot_ok), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value)
`ifdef SYSID_CHECKER_RETRY_EN
    , .retry_count(retry_count)
`endif
  );

  logic [31:0] mem0 = 32'h0, mem1 = TS_GOOD, pdata;
  int ws = 0, drop_n = 0, stall, acc0;
  bit lat0 = 0, mute = 0, stray = 0;
  logic pend, drop;
  logic acc;
  assign wr  = avm_read && (stall < ws);
  assign acc = avm_read && !wr;
  assign rdv = stray || (!mute && !drop && (lat0 ? acc : pend));
  assign rd  = stray ? 32'hDEADBEEF : lat0 ? (avm_address[0] ? mem1 : mem0) : pdata;

  always @(posedge clk or posedge rst)
    if (rst) begin
      stall <= 0; pend <= 1'b0; pdata <= '0; acc0 <= 0; drop <= 1'b0;
    end else begin
      stall <= wr ? stall + 1 : 0;
      pend  <= acc && !lat0;
      if (acc) pdata <= avm_address[0] ? mem1 : mem0;
      if (acc && !avm_address[0]) begin
        drop <= acc0 < drop_n;
        acc0 <= acc0 + 1;
      end
    end

  int tot = 0, pass = 0;

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (done !== 1'b1 && n < max);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tot++; if (avm_read !== 1'b0) $display("FAIL reset_read got=%b exp=0", avm_read); else pass++;
    tot++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass++;
    tot++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass++;
    tot++; if (boot_ok !== 1'b0) $display("FAIL reset_boot_ok got=%b exp=0", boot_ok); else pass++;
    tot++; if (id_value !== 32'h0 || ts_value !== 32'h0) $display("FAIL reset_values got=%h/%h exp=0/0", id_value, ts_value); else pass++;
    rst = 1'b0;
  endtask

  task automatic test_boot_pass();
    int n;
    wait_done(6, n);
    tot++; if (done !== 1'b1 || n > 6) $display("FAIL auto_done got=%b cycles=%0d exp=1 within 6", done, n); else pass++;
    tot++; if ({boot_ok, id_ok, ts_ok, timeout_err} !== 4'b1110) $display("FAIL auto_flags got=%b exp=1110", {boot_ok, id_ok, ts_ok, timeout_err}); else pass++;
    tot++; if (ts_value !== TS_GOOD) $display("FAIL auto_ts_value got=%0d exp=%0d", ts_value, TS_GOOD); else pass++;
    tot++; if (busy !== 1'b0) $display("FAIL auto_busy got=%b exp=0", busy); else pass++;
  endtask

  task automatic test_ts_mismatch();
    int n;
    mem1 = TS_GOOD + 32'd1;
    pulse_start();
    tot++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL restart_clears got done=%b busy=%b exp 0/1", done, busy); else pass++;
    wait_done(8, n);
    tot++; if ({done, boot_ok, id_ok, ts_ok} !== 4'b1010) $display("FAIL ts_mismatch got=%b exp=1010", {done, boot_ok, id_ok, ts_ok}); else pass++;
    tot++; if (ts_value !== TS_GOOD + 32'd1) $display("FAIL ts_mismatch_value got=%0d exp=%0d", ts_value, TS_GOOD + 32'd1); else pass++;
    mem1 = TS_GOOD;
  endtask

  task automatic test_waitrequest();
    int n, k;
    bit ok = 1;
    ws = 3;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      if (avm_read !== 1'b1 || avm_address !== 1'b0) ok = 0;
      if (i < 3) begin @(posedge clk); #1; end
    end
    tot++; if (!ok) $display("FAIL stall_id got read=%b addr=%b exp stable 1/0", avm_read, avm_address); else pass++;
    k = 0;
    while (!(avm_read === 1'b1 && avm_address === 1'b1) && k < 10) begin @(posedge clk); #1; k++; end
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (avm_read !== 1'b1 || avm_address !== 1'b1) ok = 0;
      if (i < 3) begin @(posedge clk); #1; end
    end
    tot++; if (!ok) $display("FAIL stall_ts got read=%b addr=%b exp stable 1/1", avm_read, avm_address); else pass++;
    wait_done(10, n);
    tot++; if (done !== 1'b1 || boot_ok !== 1'b1) $display("FAIL stall_boot got done=%b boot_ok=%b exp 1/1", done, boot_ok); else pass++;
    ws = 0;
  endtask

  task automatic test_zero_latency();
    int n;
    lat0 = 1;
    pulse_start();
    wait_done(6, n);
    tot++; if (n !== 2 || done !== 1'b1) $display("FAIL zero_lat_cycles got=%0d done=%b exp=2 done=1", n, done); else pass++;
    tot++; if (boot_ok !== 1'b1) $display("FAIL zero_lat_boot got=%b exp=1", boot_ok); else pass++;
    lat0 = 0;
  endtask

  task automatic test_back_to_back();
    int n;
    pulse_start();
    pulse_start();
    wait_done(8, n);
    repeat (3) @(posedge clk);
    #1;
    tot++; if (busy !== 1'b0 || done !== 1'b1) $display("FAIL start_while_busy got busy=%b done=%b exp 0/1", busy, done); else pass++;
  endtask

  task automatic test_timeout();
    int n;
    mute = 1;
    pulse_start();
    wait_done(20, n);
    tot++; if (n !== 10 || done !== 1'b1) $display("FAIL timeout_cycles got=%0d done=%b exp=10 done=1", n, done); else pass++;
    tot++; if ({timeout_err, avm_read, boot_ok} !== 3'b100) $display("FAIL timeout_flags got=%b exp=100", {timeout_err, avm_read, boot_ok}); else pass++;
    mute = 0;
    stray = 1;
    @(posedge clk); #1;
    stray = 0;
    @(posedge clk); #1;
    tot++; if (id_value !== 32'h0 || id_ok !== 1'b0 || done !== 1'b1 || busy !== 1'b0) $display("FAIL stray_valid got id=%h id_ok=%b done=%b busy=%b exp 0/0/1/0", id_value, id_ok, done, busy); else pass++;
  endtask

  task automatic test_reset_mid();
    int n, k;
    pulse_start();
    k = 0;
    while (!(busy === 1'b1 && avm_address === 1'b1 && avm_read === 1'b0) && k < 10) begin @(posedge clk); #1; k++; end
    tot++; if (k >= 10) $display("FAIL reach_ts_wait got cycles=%0d exp <10", k); else pass++;
    rst = 1'b1;
    #1;
    tot++; if ({avm_read, busy, done, boot_ok, id_ok, ts_ok} !== 6'b0 || id_value !== 32'h0 || ts_value !== 32'h0)
      $display("FAIL reset_mid got read=%b busy=%b done=%b ts=%h exp all 0", avm_read, busy, done, ts_value); else pass++;
    #1 rst = 1'b0;
    wait_done(6, n);
    tot++; if (done !== 1'b1 || boot_ok !== 1'b1) $display("FAIL reset_mid_auto got done=%b boot_ok=%b exp 1/1", done, boot_ok); else pass++;
  endtask

`ifdef SYSID_CHECKER_RETRY_EN
  task automatic test_retry();
    int n;
    rst = 1'b1;
    drop_n = 2;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done(60, n);
    tot++; if (done !== 1'b1 || boot_ok !== 1'b1 || timeout_err !== 1'b0) $display("FAIL retry_pass got done=%b boot_ok=%b to=%b exp 1/1/0", done, boot_ok, timeout_err); else pass++;
    tot++; if (retry_count !== 2'd2) $display("FAIL retry_count got=%0d exp=2", retry_count); else pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_boot_pass();
    test_ts_mismatch();
    test_waitrequest();
    test_zero_latency();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
`ifdef SYSID_CHECKER_RETRY_EN
    test_retry();
`endif
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
